hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have: id_rs1, id_rs2  in  4 each  source register addresses of the instruction in Decode.
REQ-004 SHALL have: id_use_rs1, id_use_rs2  in  1 each  Decode instruction actually reads rs1/rs2.
REQ-005 SHALL have: ex_rd  in  4; ex_wre  in  1; ex_is_load  in  1  Execute-stage destination, write enable, load flag.
REQ-006 SHALL have: mem_rd  in  4; mem_wre  in  1  Memory-stage destination and write enable.
REQ-007 SHALL have: wb_rd  in  4; wb_wre  in  1  Writeback-stage destination and write enable.
REQ-008 SHALL have: ex_branch_taken  in  1  branch/jump resolved taken in Execute.
REQ-009 SHALL have: mem_busy  in  1  data memory not ready this cycle.
REQ-010 SHALL have: pc_stall  out  1  hold PC register (drives PC nop).
REQ-011 SHALL have: fd_stall  out  1  hold Fetch-Decode register.
REQ-012 SHALL have: fd_flush  out  1  load Fetch-Decode register with nop.
REQ-013 SHALL have: de_flush  out  1  select zero control word into Decode-Execute (nop mux).
REQ-014 SHALL have: em_stall  out  1  hold Execute-Memory register and freeze Memory-Writeback input.
REQ-015 SHALL have: fwd_a, fwd_b  out  2 each  ALU operand source: 00 regfile, 01 WB data, 10 MEM ALU result.
REQ-016 SHALL have: stall_count  out  16  saturating count of cycles with pc_stall=1.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, REDIRECT; state register only sequential element besides stall_count.
REQ-018 SHALL evaluate per cycle, priority highest first: mem_busy > ex_branch_taken > load-use > none.
REQ-019 In any state, mem_busy=1 SHALL assert pc_stall, fd_stall, em_stall, de_flush=0, fd_flush=0, and enter/stay MEM_WAIT.
REQ-020 MEM_WAIT with mem_busy=0 SHALL return to RUN with all stall outputs 0 that cycle; a branch held in Execute during MEM_WAIT SHALL be handled on this release cycle per REQ-021.
REQ-021 ex_branch_taken=1 with mem_busy=0 SHALL assert fd_flush=1, de_flush=1, pc_stall=0 that cycle and enter REDIRECT.
REQ-022 REDIRECT SHALL last exactly one cycle: fd_flush=1 (discard stale synchronous-ROM word), de_flush=0, then RUN; ex_branch_taken in REDIRECT SHALL be ignored (instruction already flushed).
REQ-023 Load-use hazard SHALL be: ex_is_load & ex_wre & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-024 Load-use hazard in RUN SHALL assert pc_stall=1, fd_stall=1, de_flush=1 for exactly one cycle; FSM stays RUN.
REQ-025 fd_flush SHALL take precedence over fd_stall; both never 1 together.
REQ-026 fwd_a SHALL be 10 if mem_wre & mem_rd==ex-stage rs1 (supplied as id_rs1 registered internally at Decode-Execute advance), else 01 if wb_wre & wb_rd matches, else 00; fwd_b identical for rs2; MEM beats WB on double match.
REQ-027 Internal rs1/rs2 copies SHALL load from id_rs1/id_rs2 when de_flush=0 and em_stall=0, clear to 0 with use flags 0 when de_flush=1, hold when em_stall=1.
REQ-028 Forwarding SHALL be 00 when the corresponding registered use flag is 0.
REQ-029 stall_count SHALL increment by 1 every cycle pc_stall=1 and saturate at 0xFFFF (no wrap).
REQ-030 Stall/flush/forward outputs SHALL be combinational from state, registered copies and inputs; no extra latency.

Reset
REQ-031 reset=1 SHALL set state RUN, stall_count 0x0000, registered rs copies and use flags 0 on the next edge.
REQ-032 While reset=1, outputs SHALL be fd_flush=1, de_flush=1, pc_stall=0, fd_stall=0, em_stall=0, fwd_a=fwd_b=00.
REQ-033 reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL abort it; first cycle after release is RUN.

Verification
REQ-034 Load-use: ex_is_load=1, ex_wre=1, ex_rd=3, id_rs1=3, id_use_rs1=1 -> one cycle pc_stall=fd_stall=de_flush=1, stall_count 0->1, next cycle fwd_a=01 when load reaches WB.
REQ-035 Forward: mem_rd=5, wb_rd=5, both wre=1, registered rs2=5 -> fwd_b=10; mem_wre=0 -> fwd_b=01; rs2=0, use=0 -> 00.
REQ-036 Branch: ex_branch_taken=1 one cycle -> cycle N fd_flush=de_flush=1, cycle N+1 fd_flush=1 only, N+2 all 0.
REQ-037 Memory wait: mem_busy=1 for 3 cycles coincident with ex_branch_taken=1 -> 3 cycles pc/fd/em_stall=1, no flush; release cycle flush per REQ-021; stall_count=3.
REQ-038 Saturation and reset: force 65540 stall cycles -> stall_count=0xFFFF; reset=1 during MEM_WAIT -> count 0, RUN, flushes=1 during reset.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: stall / flush / forward control for the 5-stage pipe.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   id_rs1/2, id_use_rs1/2 Decode source registers and their use flags
//   ex_rd, ex_wre, ex_is_load  Execute destination, write enable, load flag
//   mem_rd, mem_wre       Memory-stage destination and write enable
//   wb_rd, wb_wre         Writeback-stage destination and write enable
//   ex_branch_taken       branch/jump resolved taken in Execute
//   mem_busy              data memory not ready this cycle
//   pc_stall, fd_stall    hold PC / Fetch-Decode register
//   fd_flush, de_flush    nop into Fetch-Decode / Decode-Execute
//   em_stall              hold Execute-Memory, freeze Memory-Writeback input
//   fwd_a, fwd_b          operand source: 00 regfile, 01 WB, 10 MEM
//   stall_count           saturating count of pc_stall cycles
module hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [3:0]  ex_rd,
    input  logic        ex_wre,
    input  logic        ex_is_load,
    input  logic [3:0]  mem_rd,
    input  logic        mem_wre,
    input  logic [3:0]  wb_rd,
    input  logic        wb_wre,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        fd_stall,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    state_t     state;
    state_t     state_nxt;

    // Source registers of the instruction now in Execute.
    logic [3:0] ex_rs1;
    logic [3:0] ex_rs2;
    logic       ex_use1;
    logic       ex_use2;

    logic       load_use;

    // Mutually exclusive selects, built in priority order.
    logic       sel_rst;
    logic       sel_busy;
    logic       sel_redir;
    logic       sel_branch;
    logic       sel_lu;
    logic       sel_idle;

    assign load_use = ex_is_load & ex_wre &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    assign sel_rst    = reset;
    assign sel_busy   = !reset & mem_busy;
    // The branch seen in REDIRECT was already flushed; it is ignored.
    assign sel_redir  = !reset & !mem_busy & (state == REDIRECT);
    assign sel_branch = !reset & !mem_busy & (state != REDIRECT) &
                        ex_branch_taken;
    // A MEM_WAIT release cycle raises no stall of its own.
    assign sel_lu     = !reset & !mem_busy & (state == RUN) &
                        !ex_branch_taken & load_use;
    assign sel_idle   = !(sel_rst | sel_busy | sel_redir |
                          sel_branch | sel_lu);

    always_comb begin
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        em_stall  = 1'b0;
        state_nxt = RUN;
        unique case (1'b1)
            sel_rst: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
            end
            sel_busy: begin
                pc_stall  = 1'b1;
                fd_stall  = 1'b1;
                em_stall  = 1'b1;
                state_nxt = MEM_WAIT;
            end
            sel_redir: begin
                // Drop the stale word the synchronous ROM still returns.
                fd_flush = 1'b1;
            end
            sel_branch: begin
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
                state_nxt = REDIRECT;
            end
            sel_lu: begin
                pc_stall = 1'b1;
                fd_stall = 1'b1;
                de_flush = 1'b1;
            end
            sel_idle: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1  <= 4'd0;
            ex_rs2  <= 4'd0;
            ex_use1 <= 1'b0;
            ex_use2 <= 1'b0;
        end else if (de_flush) begin
            ex_rs1  <= 4'd0;
            ex_rs2  <= 4'd0;
            ex_use1 <= 1'b0;
            ex_use2 <= 1'b0;
        end else if (!em_stall) begin
            ex_rs1  <= id_rs1;
            ex_rs2  <= id_rs2;
            ex_use1 <= id_use_rs1;
            ex_use2 <= id_use_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 16'h0000;
        end else if (pc_stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // MEM result is younger than WB data, so it wins a double match.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset) begin
            if (ex_use1 && mem_wre && mem_rd == ex_rs1) begin
                fwd_a = FWD_MEM;
            end else if (ex_use1 && wb_wre && wb_rd == ex_rs1) begin
                fwd_a = FWD_WB;
            end
            if (ex_use2 && mem_wre && mem_rd == ex_rs2) begin
                fwd_b = FWD_MEM;
            end else if (ex_use2 && wb_wre && wb_rd == ex_rs2) begin
                fwd_b = FWD_WB;
            end
        end
    end

endmodule
